// File: rtl/crypto_pkg.sv
// Shared FSM encoding and step-index constants for the crypto round controller.
package crypto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_FINISH
    } state_t;

    localparam int         STEPS         = 4;
    localparam logic [1:0] CNT_ENC_START = 2'd0;
    localparam logic [1:0] CNT_DEC_START = 2'd3;

    // Encrypt walks the step index upward from 0, decrypt walks it down from 3.
    function automatic logic [1:0] step_start(input logic decrypt);
        return decrypt ? CNT_DEC_START : CNT_ENC_START;
    endfunction

endpackage

// File: rtl/crypto_round_ctrl.sv
// Round/step sequencer for an external combinational crypto module: latches the
// operands, feeds the module one step per cycle and publishes the final word.
module crypto_round_ctrl #(
    parameter int ROUND_W = 4,
    parameter int STEPS   = crypto_pkg::STEPS
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ABORT,
    input  logic               OP_SEL,
    input  logic [ROUND_W-1:0] ROUNDS,
    input  logic [31:0]        DATA_IN,
    input  logic [31:0]        KEY_IN,
    input  logic [31:0]        CRYPTO_RESULT,
    output logic [31:0]        CRYPTO_DATA,
    output logic [31:0]        CRYPTO_KEY,
    output logic [1:0]         CRYPTO_CNT,
    output logic               CRYPTO_SEL,
    output logic               BUSY,
    output logic               DONE,
    output logic [31:0]        RESULT
);
    import crypto_pkg::*;

    localparam logic [1:0]         CNT_ENC_LAST = 2'(STEPS - 1);
    localparam logic [1:0]         CNT_DEC_LAST = CNT_ENC_START;
    localparam logic [ROUND_W-1:0] ROUND_ONE    = ROUND_W'(1);

    state_t               state_reg, state_next;
    logic [31:0]          data_reg, data_next;
    logic [31:0]          key_reg, key_next;
    logic                 sel_reg, sel_next;
    logic [ROUND_W-1:0]   rounds_reg, rounds_next;
    logic [1:0]           step_cnt_reg, step_cnt_next;
    logic [ROUND_W-1:0]   round_cnt_reg, round_cnt_next;
    logic [31:0]          result_reg, result_next;

    logic                 step_last;
    logic                 round_last;

    assign step_last  = sel_reg ? (step_cnt_reg == CNT_DEC_LAST)
                                : (step_cnt_reg == CNT_ENC_LAST);
    assign round_last = (round_cnt_reg == (rounds_reg - ROUND_ONE));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            data_reg      <= '0;
            key_reg       <= '0;
            sel_reg       <= 1'b0;
            rounds_reg    <= '0;
            step_cnt_reg  <= '0;
            round_cnt_reg <= '0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            key_reg       <= key_next;
            sel_reg       <= sel_next;
            rounds_reg    <= rounds_next;
            step_cnt_reg  <= step_cnt_next;
            round_cnt_reg <= round_cnt_next;
            result_reg    <= result_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        key_next       = key_reg;
        sel_next       = sel_reg;
        rounds_next    = rounds_reg;
        step_cnt_next  = step_cnt_reg;
        round_cnt_next = round_cnt_reg;
        result_next    = result_reg;

        case (state_reg)
            ST_IDLE: begin
                // ABORT alongside START cancels the request outright.
                if (START && !ABORT) begin
                    data_next   = DATA_IN;
                    key_next    = KEY_IN;
                    sel_next    = OP_SEL;
                    rounds_next = (ROUNDS == '0) ? ROUND_ONE : ROUNDS;
                    state_next  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    state_next = ST_IDLE;
                end else begin
                    step_cnt_next  = step_start(sel_reg);
                    round_cnt_next = '0;
                    state_next     = ST_STEP;
                end
            end
            ST_STEP: begin
                if (ABORT) begin
                    state_next = ST_IDLE;
                end else begin
                    data_next = CRYPTO_RESULT;
                    if (step_last) begin
                        step_cnt_next  = step_start(sel_reg);
                        round_cnt_next = round_cnt_reg + ROUND_ONE;
                        if (round_last) begin
                            // Capture here so RESULT is already valid while DONE is high.
                            result_next = CRYPTO_RESULT;
                            state_next  = ST_FINISH;
                        end
                    end else if (sel_reg) begin
                        step_cnt_next = step_cnt_reg - 2'd1;
                    end else begin
                        step_cnt_next = step_cnt_reg + 2'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign BUSY        = (state_reg == ST_LOAD) || (state_reg == ST_STEP);
    assign DONE        = (state_reg == ST_FINISH);
    assign CRYPTO_CNT  = (state_reg == ST_STEP) ? step_cnt_reg : 2'd0;
    assign CRYPTO_DATA = data_reg;
    assign CRYPTO_KEY  = key_reg;
    assign CRYPTO_SEL  = sel_reg;
    assign RESULT      = result_reg;

endmodule

// File: tb/tb_crypto_round_ctrl.sv
// Self-checking bench: a stub crypto module (data + key + cnt) and a closed-form
// reference for result, step sequence and latency, under directed and random ops.
module tb_crypto_round_ctrl;

    localparam int ROUND_W = 4;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic               op_sel;
    logic [ROUND_W-1:0] rounds;
    logic [31:0]        data_in;
    logic [31:0]        key_in;
    logic [31:0]        crypto_result;
    logic [31:0]        crypto_data;
    logic [31:0]        crypto_key;
    logic [1:0]         crypto_cnt;
    logic               crypto_sel;
    logic               busy;
    logic               done;
    logic [31:0]        result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_result = '0;

    crypto_round_ctrl #(.ROUND_W(ROUND_W), .STEPS(4)) dut (
        .CLK           (clk),
        .RESET         (reset),
        .START         (start),
        .ABORT         (abort),
        .OP_SEL        (op_sel),
        .ROUNDS        (rounds),
        .DATA_IN       (data_in),
        .KEY_IN        (key_in),
        .CRYPTO_RESULT (crypto_result),
        .CRYPTO_DATA   (crypto_data),
        .CRYPTO_KEY    (crypto_key),
        .CRYPTO_CNT    (crypto_cnt),
        .CRYPTO_SEL    (crypto_sel),
        .BUSY          (busy),
        .DONE          (done),
        .RESULT        (result)
    );

    assign crypto_result = crypto_data + crypto_key + 32'(crypto_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        data_in = $urandom;
        key_in  = $urandom;
        op_sel  = 1'($urandom_range(0, 1));
        rounds  = ROUND_W'($urandom_range(0, 15));
    endtask

    // Issues START in the current cycle t and checks cycles t+1 .. t+lat+1.
    // abort_at/reset_at/restart_at give the offset n at which that input is driven (-1 = never).
    task automatic run_op(input logic [31:0] d, input logic [31:0] k, input logic sel,
                          input logic [ROUND_W-1:0] r, input int abort_at,
                          input int reset_at, input int restart_at);
        int          reff;
        int          lat;
        int          s;
        logic [31:0] exp_res;
        logic [31:0] acc;
        logic [1:0]  exp_cnt;
        reff    = (r == 0) ? 1 : int'(r);
        lat     = 2 + 4 * reff;
        exp_res = d + 32'(reff) * (32'd4 * k + 32'd6);
        acc     = d;
        start   = 1'b1;
        abort   = (abort_at == 0);
        reset   = 1'b0;
        data_in = d;
        key_in  = k;
        op_sel  = sel;
        rounds  = r;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            reset = 1'b0;
            scramble_inputs();
            if (n == abort_at + 1 && abort_at < lat) begin
                check_eq("abort_busy", 32'(busy), 32'd0);
                check_eq("abort_done", 32'(done), 32'd0);
                check_eq("abort_cnt", 32'(crypto_cnt), 32'd0);
                check_eq("abort_result", result, model_result);
                $display("op sel=%0d rounds=%0d data=%h key=%h aborted at %0d", sel, r, d, k, abort_at);
                return;
            end
            if (n == reset_at + 1) begin
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_cnt", 32'(crypto_cnt), 32'd0);
                check_eq("rst_result", result, 32'd0);
                check_eq("rst_data", crypto_data, 32'd0);
                check_eq("rst_key", crypto_key, 32'd0);
                check_eq("rst_sel", 32'(crypto_sel), 32'd0);
                model_result = '0;
                $display("op sel=%0d rounds=%0d data=%h key=%h reset at %0d", sel, r, d, k, reset_at);
                return;
            end
            if (n < lat) begin
                check_eq("busy", 32'(busy), 32'd1);
                check_eq("done_early", 32'(done), 32'd0);
                check_eq("sel", 32'(crypto_sel), 32'(sel));
                check_eq("key", crypto_key, k);
                if (n == 1) begin
                    check_eq("load_cnt", 32'(crypto_cnt), 32'd0);
                    check_eq("load_data", crypto_data, d);
                end else begin
                    s       = n - 2;
                    exp_cnt = sel ? 2'(3 - (s % 4)) : 2'(s % 4);
                    check_eq("step_cnt", 32'(crypto_cnt), 32'(exp_cnt));
                    check_eq("step_data", crypto_data, acc);
                    acc = acc + k + 32'(exp_cnt);
                end
            end else if (n == lat) begin
                check_eq("done", 32'(done), 32'd1);
                check_eq("fin_busy", 32'(busy), 32'd0);
                check_eq("fin_cnt", 32'(crypto_cnt), 32'd0);
                check_eq("result", result, exp_res);
            end else begin
                check_eq("done_once", 32'(done), 32'd0);
                check_eq("idle_busy", 32'(busy), 32'd0);
                check_eq("result_hold", result, exp_res);
                model_result = exp_res;
                $display("op sel=%0d rounds=%0d data=%h key=%h result=%h latency=%0d",
                         sel, r, d, k, exp_res, lat);
            end
            if (n == restart_at) start = 1'b1;
            if (n == abort_at)   abort = 1'b1;
            if (n == reset_at)   reset = 1'b1;
        end
    endtask

    initial begin
        int reff;
        int lat;
        int mode;
        int idle;
        logic [31:0] d;
        logic [31:0] k;
        logic sel;
        logic [ROUND_W-1:0] r;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_result", result, 32'd0);
        check_eq("reset_cnt", 32'(crypto_cnt), 32'd0);
        check_eq("reset_sel", 32'(crypto_sel), 32'd0);
        check_eq("reset_data", crypto_data, 32'd0);
        check_eq("reset_key", crypto_key, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_busy", 32'(busy), 32'd0);

        run_op(32'h10, 32'h1, 1'b0, 4'd1, -1, -1, -1);
        run_op(32'h10, 32'h1, 1'b1, 4'd1, -1, -1, -1);
        run_op(32'h0,  32'h0, 1'b0, 4'd0, -1, -1, -1);
        run_op(32'h0,  32'h0, 1'b0, 4'd3, -1, -1, 5);
        run_op(32'h0,  32'h0, 1'b0, 4'd1, 4, -1, -1);
        @(negedge clk);
        check_eq("gap_busy", 32'(busy), 32'd0);
        run_op(32'h0,  32'h0, 1'b0, 4'd1, -1, -1, -1);
        run_op(32'h55, 32'h3, 1'b0, 4'd2, -1, 3, -1);
        run_op(32'h77, 32'h9, 1'b1, 4'd2, 0, -1, -1);
        run_op(32'hA5, 32'h2, 1'b1, 4'd4, lat_of(4'd4), -1, -1);

        for (int i = 0; i < 40; i++) begin
            d    = $urandom;
            k    = $urandom;
            sel  = 1'($urandom_range(0, 1));
            r    = (i % 10 == 9) ? 4'd15 : ROUND_W'($urandom_range(0, 5));
            reff = (r == 0) ? 1 : int'(r);
            lat  = 2 + 4 * reff;
            mode = $urandom_range(0, 9);
            if (mode == 0)
                run_op(d, k, sel, r, $urandom_range(0, lat), -1, -1);
            else if (mode == 1)
                run_op(d, k, sel, r, -1, $urandom_range(1, lat), -1);
            else if (mode <= 3)
                run_op(d, k, sel, r, -1, -1, $urandom_range(1, lat));
            else
                run_op(d, k, sel, r, -1, -1, -1);
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                start = 1'b0;
                abort = 1'($urandom_range(0, 1));
                scramble_inputs();
                @(negedge clk);
                check_eq("idle_busy_gap", 32'(busy), 32'd0);
                check_eq("idle_result_gap", result, model_result);
            end
            abort = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic int lat_of(input logic [ROUND_W-1:0] r);
        return 2 + 4 * ((r == 0) ? 1 : int'(r));
    endfunction

endmodule

// File: doc/crypto_round_ctrl.md
CRYPTO_ROUND_CTRL -- requirements
Module: crypto_round_ctrl

Interface
REQ-001 Parameter ROUND_W, default 4: width of the round-count input; max rounds = 2**ROUND_W-1.
REQ-002 Parameter STEPS, default 4: cryptography-module steps per round; fixed at 4 to match the 2-bit step count.
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 ABORT  in  1  cancel the operation in progress.
REQ-007 OP_SEL  in  1  0 = encrypt, 1 = decrypt; drives the module's select input.
REQ-008 ROUNDS  in  ROUND_W  number of rounds; 0 treated as 1.
REQ-009 DATA_IN  in  32  initial plaintext/ciphertext word.
REQ-010 KEY_IN  in  32  key word.
REQ-011 CRYPTO_RESULT  in  32  combinational result from the cryptography module.
REQ-012 CRYPTO_DATA  out  32  data operand to the module, equal to the working register.
REQ-013 CRYPTO_KEY  out  32  key operand to the module, equal to the latched key.
REQ-014 CRYPTO_CNT  out  2  step index to the module.
REQ-015 CRYPTO_SEL  out  1  latched OP_SEL.
REQ-016 BUSY  out  1  high in LOAD and STEP.
REQ-017 DONE  out  1  one-cycle completion pulse.
REQ-018 RESULT  out  32  final word; holds until the next DONE.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, STEP and FINISH.
REQ-020 In IDLE, START=1 with ABORT=0 SHALL latch DATA_IN, KEY_IN, OP_SEL and max(ROUNDS,1) and go to LOAD.
REQ-021 LOAD SHALL last one cycle, set the step counter to 0 for encrypt or 3 for decrypt, clear the round counter and go to STEP.
REQ-022 Each STEP cycle SHALL write CRYPTO_RESULT into the working register.
- Encrypt: step counter increments 0->3.
- Decrypt: step counter decrements 3->0.
- CRYPTO_CNT = step counter.
REQ-023 At the terminal step (3 for encrypt, 0 for decrypt), the step counter SHALL wrap to its start value and the round counter SHALL increment.
- If this was the last round, the next state SHALL be FINISH.
REQ-024 In FINISH, DONE=1 for exactly one cycle, RESULT = working register, then the next state SHALL be IDLE.
REQ-025 Latency: with START accepted at cycle t, DONE SHALL assert at cycle t+2+4R (R = effective rounds).
REQ-026 START while not in IDLE SHALL be ignored, with no queuing.
REQ-027 ABORT in LOAD or STEP SHALL return the FSM to IDLE next cycle with no DONE pulse and RESULT unchanged.
REQ-028 ABORT in FINISH SHALL have no effect; DONE still pulses.
REQ-029 START and ABORT asserted together in IDLE: ABORT SHALL win and START SHALL be ignored.
REQ-030 Inputs other than START and ABORT SHALL be ignored after latching; changing them mid-operation SHALL have no effect.
REQ-031 CRYPTO_CNT SHALL be 0 and CRYPTO_DATA/CRYPTO_KEY SHALL hold their last values outside STEP.

Reset
REQ-032 RESET=1 at a clock edge SHALL force IDLE regardless of state, including mid-operation.
REQ-033 Reset values: BUSY=0, DONE=0, RESULT=0, CRYPTO_CNT=0, CRYPTO_SEL=0, CRYPTO_DATA=0, CRYPTO_KEY=0, all counters 0.
REQ-034 RESET SHALL take priority over START and ABORT.

Structure
REQ-035 The FSM state enum and the constants STEPS, CNT_ENC_START=0 and CNT_DEC_START=3 SHALL live in a shared package, crypto_pkg.
REQ-036 No sub-module; the step/round counter SHALL be inline.
- The cryptography module SHALL be instantiated by the parent, not by this block.

Verification (bench stub module: result = data_in + key + cnt)
REQ-037 Encrypt: DATA_IN=0x10, KEY_IN=1, ROUNDS=1.
- Required: CNT sequence 0,1,2,3; DONE at t+6; RESULT=0x1A.
REQ-038 Decrypt: same inputs.
- Required: CNT sequence 3,2,1,0; RESULT=0x1A; CRYPTO_SEL=1 throughout.
REQ-039 ROUNDS=0, DATA_IN=0, KEY_IN=0.
- Required: one round executed; RESULT=6; DONE at t+6.
REQ-040 ROUNDS=3, DATA_IN=0, KEY_IN=0, encrypt.
- Required: DONE at t+14; RESULT=18; a second START at t+5 ignored.
REQ-041 ABORT at t+4, then START at t+6 with DATA_IN=0, KEY_IN=0, ROUNDS=1.
- Required: no DONE from the first operation; second DONE at t+12 with RESULT=6.
REQ-042 RESET at t+3 during STEP.
- Required: next cycle BUSY=0, CRYPTO_CNT=0, RESULT=0, FSM in IDLE; START+ABORT together then produces no BUSY.
